// File: rtl/car_gen_pkg.sv
// Shared types and sensor patterns for the parking-lot stimulus generator.
// Pure definitions; no latency or flow-control behaviour of its own.
package car_gen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    RET1 = 3'd4,
    GAP  = 3'd5
  } gen_state_t;

  typedef enum logic {
    DIR_ENTRY = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_t;

  // bit0 = outer sensor1, bit1 = inner sensor2; 1 = beam blocked
  localparam logic [1:0] ENTRY_PH1 = 2'b01;
  localparam logic [1:0] ENTRY_PH2 = 2'b11;
  localparam logic [1:0] ENTRY_PH3 = 2'b10;
  localparam logic [1:0] EXIT_PH1  = 2'b10;
  localparam logic [1:0] EXIT_PH2  = 2'b11;
  localparam logic [1:0] EXIT_PH3  = 2'b01;

  function automatic logic [1:0] phase_pattern(input gen_state_t st, input dir_t dir);
    logic [1:0] pat;
    pat = 2'b00;
    case (st)
      PH1, RET1: pat = (dir == DIR_ENTRY) ? ENTRY_PH1 : EXIT_PH1;
      PH2:       pat = (dir == DIR_ENTRY) ? ENTRY_PH2 : EXIT_PH2;
      PH3:       pat = (dir == DIR_ENTRY) ? ENTRY_PH3 : EXIT_PH3;
      default:   pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts tick strobes within one phase; expire is combinational on the final tick.
// No backpressure: clr wins over counting and restarts the phase at zero.
module dwell_timer #(
  parameter int HOLD_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int CNT_W = $clog2(HOLD_TICKS + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = tick && (cnt == CNT_W'(HOLD_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/car_sequence_gen.sv
// Drives the two photo-sensor lines through a legal entry/exit sequence; 1 clk request-to-sensor latency.
// No backpressure: requests while busy are dropped and flagged with a one-clk reject pulse.
module car_sequence_gen
  import car_gen_pkg::*;
#(
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic       abort,
  output logic [1:0] sensor,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       reject
);

  gen_state_t state;
  dir_t       dir;
  logic       abort_flag;
  logic       expire;
  logic       clr;
  logic       req;

  assign req = enter_req | exit_req;

  // The counter restarts whenever the FSM leaves a state early (request or abort);
  // dwell-end transitions restart it inside the timer.
  assign clr = (state == IDLE) || (abort && ((state == PH1) || (state == PH2)));

  dwell_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .tick   (tick),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= DIR_ENTRY;
      abort_flag <= 1'b0;
      sensor     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      reject     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      reject  <= req && (state != IDLE);
      case (state)
        IDLE: begin
          if (enter_req) begin
            state      <= PH1;
            dir        <= DIR_ENTRY;
            sensor     <= ENTRY_PH1;
            busy       <= 1'b1;
            abort_flag <= 1'b0;
          end else if (exit_req) begin
            state      <= PH1;
            dir        <= DIR_EXIT;
            sensor     <= EXIT_PH1;
            busy       <= 1'b1;
            abort_flag <= 1'b0;
          end
        end
        PH1: begin
          if (abort) begin
            state      <= GAP;
            sensor     <= 2'b00;
            abort_flag <= 1'b1;
          end else if (expire) begin
            state  <= PH2;
            sensor <= phase_pattern(PH2, dir);
          end
        end
        PH2: begin
          // Backing out from the both-blocked phase retraces through PH1's pattern.
          if (abort) begin
            state      <= RET1;
            sensor     <= phase_pattern(RET1, dir);
            abort_flag <= 1'b1;
          end else if (expire) begin
            state  <= PH3;
            sensor <= phase_pattern(PH3, dir);
          end
        end
        PH3, RET1: begin
          if (expire) begin
            state  <= GAP;
            sensor <= 2'b00;
          end
        end
        GAP: begin
          if (expire) begin
            state      <= IDLE;
            sensor     <= 2'b00;
            busy       <= 1'b0;
            done       <= !abort_flag;
            aborted    <= abort_flag;
            abort_flag <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          sensor <= 2'b00;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_sequence_gen.sv
// Scoreboard bench for car_sequence_gen with HOLD_TICKS=2.
// Expected per-cycle outputs are queued before each scenario and popped as the DUT runs.
module tb_car_sequence_gen;

  localparam int HOLD = 2;

  typedef struct packed {
    logic [1:0] sensor;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       reject;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       enter_req;
  logic       exit_req;
  logic       abort;
  logic [1:0] sensor;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       reject;

  obs_t sb[$];
  obs_t exp_v;
  obs_t obs_v;
  int   n_cmp = 0;
  int   n_err = 0;

  car_sequence_gen #(
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .enter_req (enter_req),
    .exit_req  (exit_req),
    .abort     (abort),
    .sensor    (sensor),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .reject    (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t cur();
    obs_t o;
    o.sensor  = sensor;
    o.busy    = busy;
    o.done    = done;
    o.aborted = aborted;
    o.reject  = reject;
    return o;
  endfunction

  function automatic void push_n(input int n, input logic [1:0] s, input logic b,
                                 input logic d, input logic a, input logic r);
    obs_t t;
    t.sensor  = s;
    t.busy    = b;
    t.done    = d;
    t.aborted = a;
    t.reject  = r;
    for (int i = 0; i < n; i++) sb.push_back(t);
  endfunction

  // Full normal sequence: three phases, gap, then the done cycle.
  function automatic void push_seq(input logic [1:0] p1, input logic [1:0] p2,
                                   input logic [1:0] p3);
    push_n(HOLD, p1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(HOLD, p2, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(HOLD, p3, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(HOLD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic idle_inputs();
    enter_req = 1'b0;
    exit_req  = 1'b0;
    abort     = 1'b0;
    tick      = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    enter_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs_v = cur();
    n_cmp++;
    if (obs_v !== 6'b0) begin
      n_err++;
      $display("FAIL reset_hold got %b want %b", obs_v, 6'b0);
    end
    enter_req = 1'b0;
    rst = 1'b1;
    sb.delete();
    push_n(3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_idle c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_entry();
    sb.delete();
    push_seq(2'b01, 2'b11, 2'b10);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL entry c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_exit();
    sb.delete();
    push_seq(2'b10, 2'b11, 2'b01);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      exit_req = (c == 0);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL exit c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort_ph2();
    sb.delete();
    push_n(2, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(2, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      abort     = (c == 3);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL abort_ph2 c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort_edges();
    // Abort in PH1 goes straight to the gap.
    sb.delete();
    push_n(1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(HOLD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      abort     = (c == 1);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL abort_ph1 c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    // Abort in PH3, GAP and IDLE is ignored.
    sb.delete();
    push_seq(2'b01, 2'b11, 2'b10);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      abort     = (c == 5) || (c == 7) || (c == 9);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL abort_late c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    sb.delete();
    push_seq(2'b01, 2'b11, 2'b10);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb[4].reject = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      exit_req  = (c == 0) || (c == 4);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL contention c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_held_reject();
    sb.delete();
    push_seq(2'b01, 2'b11, 2'b10);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb[1].reject = 1'b1;
    sb[2].reject = 1'b1;
    sb[3].reject = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      enter_req = (c <= 3);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL held_reject c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_slow_tick();
    logic [1:0] prev;
    prev = 2'b00;
    sb.delete();
    push_n(4 * HOLD, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(4 * HOLD, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(4 * HOLD, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(4 * HOLD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 34; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      tick      = (c % 4 == 0);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL slow_tick c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
      if (obs_v.sensor !== prev) begin
        n_cmp++;
        if ($countones(obs_v.sensor ^ prev) != 1) begin
          n_err++;
          $display("FAIL single_bit c%0d got %b->%b want one bit change", c + 1, prev, obs_v.sensor);
        end
        prev = obs_v.sensor;
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    sb.delete();
    push_seq(2'b10, 2'b11, 2'b01);
    push_seq(2'b01, 2'b11, 2'b10);
    push_n(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 19; c++) begin
      idle_inputs();
      exit_req  = (c == 0);
      enter_req = (c == 4 * HOLD + 1);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    sb.delete();
    push_n(2, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n(1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      enter_req = (c == 0);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_pre c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (sensor !== 2'b00) begin
      n_err++;
      $display("FAIL reset_async_sensor got %b want 00", sensor);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_busy got %b want 0", busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    push_n(12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = cur();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_post c%0d got %b want %b", c + 1, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_abort_ph2();
    test_abort_edges();
    test_contention();
    test_held_reject();
    test_slow_tick();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/car_sequence_gen.md
Name: car_sequence_gen

Overview:
Stimulus transmitter for the parking-lot sensor protocol. On request it drives the two photo-sensor lines through a legal vehicle entry or exit sequence. It is the encoder counterpart of the sensor-decoding FSM. It sits in the self-test/demo top, with its sensor output muxed onto the FSM's sensor inputs. Phase dwell time is measured in strobes from an external clk_divider tick, so sequences are human-visible on the board and short in simulation.

Parameters:
HOLD_TICKS, 4, tick strobes each phase is held (legal range 1 to 255).
CNT_W, $clog2(HOLD_TICKS+1), dwell counter width (derived, not overridden).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-clk phase-time strobe from clk_divider
enter_req  in  1  start entry sequence (sampled every clk)
exit_req  in  1  start exit sequence (sampled every clk)
abort  in  1  vehicle backs out (sampled every clk)
sensor  out  2  [0]=outer sensor1, [1]=inner sensor2; 1 = beam blocked
busy  out  1  sequence in progress
done  out  1  one-clk pulse: sequence completed normally
aborted  out  1  one-clk pulse: sequence completed via retrace
reject  out  1  one-clk pulse: request arrived while busy

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, sensor=00, busy=0, done=0, aborted=0, reject=0, dwell counter=0, dir=entry. Reset may assert at any point, including mid-sequence, and forces sensor=00 immediately.
- States: IDLE, PH1, PH2, PH3, RET1, GAP.
- Patterns, entry (dir=0): PH1=01, PH2=11, PH3=10.
- Patterns, exit (dir=1): PH1=10, PH2=11, PH3=01.
- RET1 drives the PH1 pattern of the current dir. GAP and IDLE drive 00.
- IDLE, request accepted:
  - enter_req=1 at a clk edge: dir<=0, state<=PH1. From the next cycle sensor=01 and busy=1 (latency 1 clk).
  - exit_req=1: dir<=1, state<=PH1.
  - Both requests high together: entry wins, no reject.
- Dwell timing:
  - The counter clears on every state entry and increments only on tick=1.
  - A phase ends on a clk edge where tick=1 and count==HOLD_TICKS-1.
  - Each phase therefore lasts exactly HOLD_TICKS ticks.
- Normal path: PH1 -> PH2 -> PH3 -> GAP -> IDLE. done=1 for the first IDLE cycle. busy falls in that same cycle.
- Abort handling:
  - Abort in PH1: go to GAP immediately, set the abort flag.
  - Abort in PH2: go to RET1, set the abort flag. RET1 -> GAP on dwell end.
  - Abort in PH3, GAP, RET1 or IDLE: ignored (vehicle committed or already leaving).
  - If the abort flag is set, leaving GAP pulses aborted instead of done, then the flag clears.
- The sensor never goes from 00 to 11, or from 01 to 10 directly, in any path. Only single-bit changes between consecutive patterns are allowed.
- reject:
  - Pulses the cycle after any clk edge where (enter_req|exit_req)=1 and state!=IDLE.
  - A held request while busy yields a reject on every cycle.
  - Rejected requests are dropped, not queued.
- A request arriving in the same cycle done or aborted is high is accepted, since state is IDLE.

Decomposition:
- car_gen_pkg holds:
  - the state enum typedef gen_state_t;
  - localparams ENTRY_PH1/PH2/PH3 and EXIT_PH1/PH2/PH3 (2-bit patterns);
  - typedef dir_t.
- One sub-module: dwell_timer (HOLD_TICKS param; inputs clr, tick; output expire). It is the tick counter, cleared on state change.
- The FSM and output registers live in car_sequence_gen.

Test Plan:
All scenarios use HOLD_TICKS=2, tick=1 every clk, and the request pulse at edge 0 unless stated.
1. Entry: enter_req pulse -> sensor 01 in cycles 1-2, 11 in 3-4, 10 in 5-6, 00 in 7-8. done=1 in cycle 9 only; busy=1 in cycles 1-8.
2. Exit: exit_req pulse -> sensor 10,10,11,11,01,01,00,00. done in cycle 9. Chaining into the sensor FSM plus contador moves the count 1->0.
3. Abort in PH2: enter_req, then abort=1 in cycle 3 -> sensor 01,01,11,01,01,00,00. aborted=1 in cycle 8; done never asserts; the count is unchanged.
4. Contention: enter_req and exit_req both high at edge 0 -> entry sequence. exit_req pulsed in cycle 4 -> reject=1 in cycle 5; sequence unaffected.
5. Slow tick: tick every 4th clk -> each phase lasts exactly 8 clks. Only single-bit transitions occur (assert on every sensor change).
6. Reset mid-sequence: rst=0 during PH2 -> sensor=00 and busy=0 asynchronously. After release, IDLE; no done or aborted pulse.
